// File: rtl/snn_lif_layer.sv
// Layer of N_OUT leaky integrate-and-fire neurons sharing one binary pixel vector.
// Weights are accumulated serially, one input per cycle, over T_STEPS time steps.
module snn_lif_layer #(
    parameter int unsigned N_IN       = 16,
    parameter int unsigned N_OUT      = 4,
    parameter int unsigned W_WIDTH    = 16,
    parameter int unsigned V_WIDTH    = 32,
    parameter int unsigned T_STEPS    = 8,
    parameter int unsigned LEAK_SHIFT = 3,
    parameter int unsigned REFRAC     = 2
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     start,
    input  logic                                     in_valid,
    output logic                                     in_ready,
    input  logic [N_IN-1:0]                          pixel,
    input  logic [N_OUT*N_IN*W_WIDTH-1:0]            weight,
    input  logic signed [V_WIDTH-1:0]                threshold,
    output logic                                     busy,
    output logic                                     spike_valid,
    output logic [N_OUT-1:0]                         spike_out,
    output logic                                     done,
    output logic [$clog2(N_OUT)-1:0]                 winner,
    output logic [N_OUT*$clog2(T_STEPS+1)-1:0]       spike_count
);
    localparam int unsigned IDX_W = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam int unsigned T_W   = (T_STEPS > 1) ? $clog2(T_STEPS) : 1;
    localparam int unsigned CNT_W = $clog2(T_STEPS + 1);
    localparam int unsigned RF_W  = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;
    localparam int unsigned WIN_W = $clog2(N_OUT);

    localparam logic signed [V_WIDTH-1:0] V_MAX = {1'b0, {(V_WIDTH-1){1'b1}}};
    localparam logic signed [V_WIDTH-1:0] V_MIN = {1'b1, {(V_WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_IN,
        S_ACCUM,
        S_FIRE,
        S_DONE
    } state_e;

    state_e                     state_q, state_d;
    logic signed [V_WIDTH-1:0]  v_q [N_OUT];
    logic signed [V_WIDTH-1:0]  v_d [N_OUT];
    logic [RF_W-1:0]            refrac_q [N_OUT];
    logic [RF_W-1:0]            refrac_d [N_OUT];
    logic [CNT_W-1:0]           cnt_q [N_OUT];
    logic [CNT_W-1:0]           cnt_d [N_OUT];
    logic [IDX_W-1:0]           idx_q, idx_d;
    logic [T_W-1:0]             t_q, t_d;
    logic [N_IN-1:0]            pix_q, pix_d;
    logic                       busy_q, busy_d;
    logic                       in_ready_q, in_ready_d;
    logic                       spike_valid_q, spike_valid_d;
    logic [N_OUT-1:0]           spike_out_q, spike_out_d;
    logic                       done_q, done_d;
    logic [WIN_W-1:0]           winner_q, winner_d;

    logic signed [V_WIDTH-1:0]  acc_v [N_OUT];
    logic signed [V_WIDTH-1:0]  leak_v [N_OUT];
    logic [CNT_W-1:0]           best_cnt;
    logic [WIN_W-1:0]           best_idx;

    // Signed add that clamps at the potential range instead of wrapping.
    function automatic logic signed [V_WIDTH-1:0] sat_add(
        input logic signed [V_WIDTH-1:0] a,
        input logic signed [W_WIDTH-1:0] b
    );
        logic signed [V_WIDTH:0] s;
        s = (V_WIDTH+1)'(a) + (V_WIDTH+1)'(b);
        if (s[V_WIDTH] != s[V_WIDTH-1]) begin
            sat_add = s[V_WIDTH] ? V_MIN : V_MAX;
        end else begin
            sat_add = s[V_WIDTH-1:0];
        end
    endfunction

    // Per-neuron candidate potentials for the current input and for the leak.
    always_comb begin
        for (int n = 0; n < N_OUT; n++) begin
            acc_v[n]  = sat_add(v_q[n], weight[(n*N_IN + int'(idx_q))*W_WIDTH +: W_WIDTH]);
            leak_v[n] = v_q[n] - (v_q[n] >>> LEAK_SHIFT);
        end
    end

    always_comb begin
        state_d       = state_q;
        v_d           = v_q;
        refrac_d      = refrac_q;
        cnt_d         = cnt_q;
        idx_d         = idx_q;
        t_d           = t_q;
        pix_d         = pix_q;
        spike_out_d   = '0;
        spike_valid_d = 1'b0;
        done_d        = 1'b0;
        winner_d      = winner_q;

        // Strict greater-than keeps ties on the lowest index.
        best_cnt = cnt_q[0];
        best_idx = '0;
        for (int n = 1; n < N_OUT; n++) begin
            if (cnt_q[n] > best_cnt) begin
                best_cnt = cnt_q[n];
                best_idx = WIN_W'(n);
            end
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    for (int n = 0; n < N_OUT; n++) begin
                        v_d[n]      = '0;
                        refrac_d[n] = '0;
                        cnt_d[n]    = '0;
                    end
                    t_d      = '0;
                    winner_d = '0;
                    state_d  = S_WAIT_IN;
                end
            end
            S_WAIT_IN: begin
                if (in_valid) begin
                    pix_d   = pixel;
                    idx_d   = '0;
                    state_d = S_ACCUM;
                end
            end
            S_ACCUM: begin
                for (int n = 0; n < N_OUT; n++) begin
                    if (refrac_q[n] == '0 && pix_q[idx_q]) begin
                        v_d[n] = acc_v[n];
                    end
                end
                if (idx_q == IDX_W'(N_IN - 1)) begin
                    state_d = S_FIRE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            S_FIRE: begin
                for (int n = 0; n < N_OUT; n++) begin
                    if (refrac_q[n] != '0) begin
                        v_d[n]      = '0;
                        refrac_d[n] = refrac_q[n] - RF_W'(1);
                    end else if (leak_v[n] >= threshold) begin
                        v_d[n]         = '0;
                        refrac_d[n]    = RF_W'(REFRAC);
                        cnt_d[n]       = cnt_q[n] + CNT_W'(1);
                        spike_out_d[n] = 1'b1;
                    end else begin
                        v_d[n] = leak_v[n];
                    end
                end
                spike_valid_d = 1'b1;
                if (t_q == T_W'(T_STEPS - 1)) begin
                    state_d = S_DONE;
                end else begin
                    t_d     = t_q + T_W'(1);
                    state_d = S_WAIT_IN;
                end
            end
            S_DONE: begin
                winner_d = best_idx;
                done_d   = 1'b1;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d     = (state_d != S_IDLE);
        in_ready_d = (state_d == S_WAIT_IN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            for (int n = 0; n < N_OUT; n++) begin
                v_q[n]      <= '0;
                refrac_q[n] <= '0;
                cnt_q[n]    <= '0;
            end
            idx_q         <= '0;
            t_q           <= '0;
            pix_q         <= '0;
            busy_q        <= 1'b0;
            in_ready_q    <= 1'b0;
            spike_valid_q <= 1'b0;
            spike_out_q   <= '0;
            done_q        <= 1'b0;
            winner_q      <= '0;
        end else begin
            state_q       <= state_d;
            v_q           <= v_d;
            refrac_q      <= refrac_d;
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            t_q           <= t_d;
            pix_q         <= pix_d;
            busy_q        <= busy_d;
            in_ready_q    <= in_ready_d;
            spike_valid_q <= spike_valid_d;
            spike_out_q   <= spike_out_d;
            done_q        <= done_d;
            winner_q      <= winner_d;
        end
    end

    always_comb begin
        spike_count = '0;
        for (int n = 0; n < N_OUT; n++) begin
            spike_count[n*CNT_W +: CNT_W] = cnt_q[n];
        end
    end

    assign busy        = busy_q;
    assign in_ready    = in_ready_q;
    assign spike_valid = spike_valid_q;
    assign spike_out   = spike_out_q;
    assign done        = done_q;
    assign winner      = winner_q;

endmodule
